// File: rtl/frame_sync_detector.sv
// OFDM packet-boundary detector: magnitude vs. delay-correlation run detection with frame start/end strobes.
// Latency: the input pair on cycle n drives the FSM outputs on cycle n+3 (two pipeline stages plus a registered FSM).
// Backpressure: none. One pair is accepted per clock. Optional max-length abort is enabled by FRAME_SYNC_MAXLEN_EN.
module frame_sync_detector #(
  parameter int                DATA_W        = 21,
  parameter int                SHIFT         = 10,
  parameter int                START_RUN     = 32,
  parameter int                END_RUN       = 48,
  parameter logic [DATA_W-1:0] END_THRESH    = 21'h07001,
  parameter int                HOLDOFF       = 16,
  parameter int                CNT_W         = 16,
  parameter int                MAX_FRAME_LEN = 4096
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              SumMagnituderEnable,
  input  logic [DATA_W-1:0] SumMagnituder,
  input  logic              SumDelayCorrelationEnable,
  input  logic [DATA_W-1:0] SumDelayCorrelation,
  output logic              FrameFind,
  output logic              FrameStart,
  output logic              FrameEnd,
  output logic [CNT_W-1:0]  FrameLen,
  output logic              FrameAbort
);

  // Reject configurations the run/length counters cannot represent.
  if (START_RUN < 1 || START_RUN >= 2**CNT_W) begin : g_bad_start_run
    $error("frame_sync_detector: START_RUN out of range");
  end
  if (END_RUN < 1 || END_RUN >= 2**CNT_W) begin : g_bad_end_run
    $error("frame_sync_detector: END_RUN out of range");
  end
  if (HOLDOFF < 0 || HOLDOFF >= 2**CNT_W) begin : g_bad_holdoff
    $error("frame_sync_detector: HOLDOFF out of range");
  end
  if (MAX_FRAME_LEN < 1 || MAX_FRAME_LEN >= 2**CNT_W) begin : g_bad_max_len
    $error("frame_sync_detector: MAX_FRAME_LEN out of range");
  end

  localparam int               HOLD_LAST_I = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_RUN - 1);
  localparam logic [CNT_W-1:0] END_LAST    = CNT_W'(END_RUN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_LAST_I);
  localparam logic [CNT_W-1:0] LEN_SAT     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // Stage 1 registers
  logic              s1_vld;
  logic [DATA_W-1:0] s1_mag;
  logic [DATA_W-1:0] s1_corr;

  // Stage 2 registers
  logic s2_vld;
  logic s2_det;
  logic s2_low;

  // FSM state and counters
  state_t           state, state_nxt;
  logic [CNT_W-1:0] start_cnt, start_cnt_nxt;
  logic [CNT_W-1:0] end_cnt, end_cnt_nxt;
  logic [CNT_W-1:0] len_cnt, len_cnt_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [CNT_W-1:0] frame_len, frame_len_nxt;
  logic             start_nxt, end_nxt, abort_nxt;
  logic             frame_start, frame_end, frame_abort;

  logic             pair_vld;
  logic [CNT_W-1:0] len_inc;
  logic             end_run_hit;
  logic             abort_hit;
  state_t           after_lock;

  assign pair_vld = SumMagnituderEnable & SumDelayCorrelationEnable;

  // Stage 1: capture the pair; data is forced to zero when the pair is not valid.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_vld  <= 1'b0;
      s1_mag  <= '0;
      s1_corr <= '0;
    end else begin
      s1_vld  <= pair_vld;
      s1_mag  <= pair_vld ? SumMagnituder : '0;
      s1_corr <= pair_vld ? SumDelayCorrelation : '0;
    end
  end

  // Stage 2: detection and low-energy compares, qualified by the valid flag.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s2_vld <= 1'b0;
      s2_det <= 1'b0;
      s2_low <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      s2_det <= s1_vld & ((s1_mag >> SHIFT) < s1_corr);
      s2_low <= s1_vld & (s1_mag < END_THRESH);
    end
  end

  // Length including the current pair, saturating at the counter maximum.
  assign len_inc     = (len_cnt == LEN_SAT) ? len_cnt : len_cnt + CNT_W'(1);
  assign end_run_hit = s2_low && (end_cnt == END_LAST);
  assign after_lock  = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;

`ifdef FRAME_SYNC_MAXLEN_EN
  assign abort_hit = (len_inc == CNT_W'(MAX_FRAME_LEN));
`else
  assign abort_hit = 1'b0;
`endif

  // FSM next-state, counter updates and strobe generation.
  always_comb begin
    state_nxt     = state;
    start_cnt_nxt = start_cnt;
    end_cnt_nxt   = end_cnt;
    len_cnt_nxt   = len_cnt;
    hold_cnt_nxt  = hold_cnt;
    frame_len_nxt = frame_len;
    start_nxt     = 1'b0;
    end_nxt       = 1'b0;
    abort_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s2_vld && s2_det) begin
          if (start_cnt == START_LAST) begin
            state_nxt     = ST_LOCKED;
            start_nxt     = 1'b1;
            start_cnt_nxt = '0;
            len_cnt_nxt   = '0;
            end_cnt_nxt   = '0;
          end else begin
            start_cnt_nxt = start_cnt + CNT_W'(1);
          end
        end else begin
          start_cnt_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (!s2_vld) begin
          // A validity gap terminates the frame without counting the gap.
          state_nxt     = after_lock;
          end_nxt       = 1'b1;
          frame_len_nxt = len_cnt;
          end_cnt_nxt   = '0;
          hold_cnt_nxt  = '0;
        end else begin
          len_cnt_nxt = len_inc;
          end_cnt_nxt = s2_low ? end_cnt + CNT_W'(1) : '0;
          if (end_run_hit) begin
            // Natural end wins over an abort on the same pair.
            state_nxt     = after_lock;
            end_nxt       = 1'b1;
            frame_len_nxt = len_inc;
            end_cnt_nxt   = '0;
            hold_cnt_nxt  = '0;
          end else if (abort_hit) begin
            state_nxt     = after_lock;
            end_nxt       = 1'b1;
            abort_nxt     = 1'b1;
            frame_len_nxt = len_inc;
            end_cnt_nxt   = '0;
            hold_cnt_nxt  = '0;
          end
        end
      end
      ST_HOLDOFF: begin
        // Pairs are ignored here; only clock cycles are counted.
        start_cnt_nxt = '0;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt    = ST_IDLE;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and registered strobes.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= ST_IDLE;
      start_cnt   <= '0;
      end_cnt     <= '0;
      len_cnt     <= '0;
      hold_cnt    <= '0;
      frame_len   <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_cnt   <= start_cnt_nxt;
      end_cnt     <= end_cnt_nxt;
      len_cnt     <= len_cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
      frame_len   <= frame_len_nxt;
      frame_start <= start_nxt;
      frame_end   <= end_nxt;
      frame_abort <= abort_nxt;
    end
  end

  assign FrameFind  = (state == ST_LOCKED);
  assign FrameStart = frame_start;
  assign FrameEnd   = frame_end;
  assign FrameLen   = frame_len;
  assign FrameAbort = frame_abort;

endmodule

// File: tb/tb_frame_sync_detector.sv
// Bench for frame_sync_detector: directed pair sequences with hand-computed strobe cycles and frame lengths.
// Expected events are queued at stimulus time; a negedge monitor pops and compares each observed strobe.
// Two instances: default run lengths (MAX_FRAME_LEN=100) and a minimal START_RUN=1/END_RUN=1/HOLDOFF=0 one.
module tb_frame_sync_detector;

  typedef struct {
    logic        st;
    logic        en;
    logic        ab;
    int          cyc;
    logic [15:0] len;
  } exp_t;

  localparam logic [20:0] MAG_HI = 21'h10000;  // >>10 = 64, above END_THRESH
  localparam logic [20:0] MAG_LO = 21'h01000;  // below END_THRESH

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];

  logic        a_men = 1'b0, a_cen = 1'b0;
  logic [20:0] a_mag = '0, a_corr = '0;
  logic        a_find, a_start, a_end, a_abort;
  logic [15:0] a_len;

  logic        b_men = 1'b0, b_cen = 1'b0;
  logic [20:0] b_mag = '0, b_corr = '0;
  logic        b_find, b_start, b_end, b_abort;
  logic [15:0] b_len;

  frame_sync_detector #(.MAX_FRAME_LEN(100)) dut_a (
    .Clk                       (Clk),
    .Rst_n                     (Rst_n),
    .SumMagnituderEnable       (a_men),
    .SumMagnituder             (a_mag),
    .SumDelayCorrelationEnable (a_cen),
    .SumDelayCorrelation       (a_corr),
    .FrameFind                 (a_find),
    .FrameStart                (a_start),
    .FrameEnd                  (a_end),
    .FrameLen                  (a_len),
    .FrameAbort                (a_abort)
  );

  frame_sync_detector #(.START_RUN(1), .END_RUN(1), .HOLDOFF(0)) dut_b (
    .Clk                       (Clk),
    .Rst_n                     (Rst_n),
    .SumMagnituderEnable       (b_men),
    .SumMagnituder             (b_mag),
    .SumDelayCorrelationEnable (b_cen),
    .SumDelayCorrelation       (b_corr),
    .FrameFind                 (b_find),
    .FrameStart                (b_start),
    .FrameEnd                  (b_end),
    .FrameLen                  (b_len),
    .FrameAbort                (b_abort)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected strobe for the pair about to be driven this cycle.
  task automatic push_a(input logic st, input logic en, input logic ab, input int len);
    exp_a.push_back('{st: st, en: en, ab: ab, cyc: cyc + 3, len: 16'(len)});
  endtask

  task automatic push_b(input logic st, input logic en, input logic ab, input int len);
    exp_b.push_back('{st: st, en: en, ab: ab, cyc: cyc + 3, len: 16'(len)});
  endtask

  task automatic pair_a(input logic me, input logic ce, input logic [20:0] m, input logic [20:0] c);
    a_men = me; a_cen = ce; a_mag = m; a_corr = c;
    @(posedge Clk); #1;
  endtask

  task automatic pair_b(input logic me, input logic ce, input logic [20:0] m, input logic [20:0] c);
    b_men = me; b_cen = ce; b_mag = m; b_corr = c;
    @(posedge Clk); #1;
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge Clk) begin
    exp_t e;
    while (exp_a.size() > 0 && exp_a[0].cyc < cyc) begin
      e = exp_a.pop_front();
      chk("a_missed_event_cycle", cyc, e.cyc);
    end
    while (exp_b.size() > 0 && exp_b[0].cyc < cyc) begin
      e = exp_b.pop_front();
      chk("b_missed_event_cycle", cyc, e.cyc);
    end
    if (a_start || a_end || a_abort) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected_event", {a_start, a_end, a_abort}, 0);
      end else begin
        e = exp_a.pop_front();
        chk("a_kind", {a_start, a_end, a_abort}, {e.st, e.en, e.ab});
        chk("a_cycle", cyc, e.cyc);
        chk("a_find", a_find, e.st);
        if (e.en) chk("a_len", a_len, e.len);
      end
    end
    if (b_start || b_end || b_abort) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected_event", {b_start, b_end, b_abort}, 0);
      end else begin
        e = exp_b.pop_front();
        chk("b_kind", {b_start, b_end, b_abort}, {e.st, e.en, e.ab});
        chk("b_cycle", cyc, e.cyc);
        chk("b_find", b_find, e.st);
        if (e.en) chk("b_len", b_len, e.len);
      end
    end
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_find", a_find, 0);
    chk("rst_start", a_start, 0);
    chk("rst_end", a_end, 0);
    chk("rst_len", a_len, 0);
    chk("rst_abort", a_abort, 0);
    chk("rst_b_find", b_find, 0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Near miss: 31 qualifying pairs then a non-qualifying one, then a full run.
    for (int i = 0; i < 31; i++) pair_a(1, 1, MAG_HI, 21'd100);
    pair_a(1, 1, MAG_HI, 21'd10);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) push_a(1, 0, 0, 0);
      pair_a(1, 1, MAG_HI, 21'd100);
    end

    // Natural end: 20 high pairs, 48 low pairs.
    for (int i = 0; i < 20; i++) pair_a(1, 1, MAG_HI, 21'd100);
    for (int i = 0; i < 48; i++) begin
      if (i == 47) push_a(0, 1, 0, 68);
      pair_a(1, 1, MAG_LO, 21'd100);
    end

    // Hold-off: first 16 qualifying pairs are ignored, lock on the 48th.
    for (int j = 1; j <= 48; j++) begin
      if (j == 48) push_a(1, 0, 0, 0);
      pair_a(1, 1, MAG_HI, 21'd100);
    end

    // Validity gap after 10 pairs.
    for (int i = 0; i < 10; i++) pair_a(1, 1, MAG_HI, 21'd100);
    push_a(0, 1, 0, 10);
    pair_a(1, 0, MAG_HI, 21'd100);
    for (int i = 0; i < 20; i++) pair_a(0, 0, '0, '0);
    chk("gap_len_held", a_len, 10);
    chk("gap_find_low", a_find, 0);

    // Maximum length: 100 high pairs after lock.
    for (int i = 0; i < 32; i++) begin
      if (i == 31) push_a(1, 0, 0, 0);
      pair_a(1, 1, MAG_HI, 21'd100);
    end
    for (int i = 0; i < 100; i++) begin
`ifdef FRAME_SYNC_MAXLEN_EN
      if (i == 99) push_a(0, 1, 1, 100);
`endif
      pair_a(1, 1, MAG_HI, 21'd100);
    end
`ifdef FRAME_SYNC_MAXLEN_EN
    chk("maxlen_find_low", a_find, 0);
`else
    chk("maxlen_find_high", a_find, 1);
    push_a(0, 1, 0, 100);
`endif
    for (int i = 0; i < 25; i++) pair_a(0, 0, '0, '0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 32; i++) begin
      if (i == 31) push_a(1, 0, 0, 0);
      pair_a(1, 1, MAG_HI, 21'd100);
    end
    for (int i = 0; i < 5; i++) pair_a(1, 1, MAG_HI, 21'd100);
    chk("pre_reset_find", a_find, 1);
    a_men = 1'b0; a_cen = 1'b0;
    Rst_n = 1'b0;
    #2;
    chk("midrst_find", a_find, 0);
    chk("midrst_start", a_start, 0);
    chk("midrst_end", a_end, 0);
    chk("midrst_len", a_len, 0);
    chk("midrst_abort", a_abort, 0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) pair_a(0, 0, '0, '0);
    chk("post_reset_find", a_find, 0);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) push_a(1, 0, 0, 0);
      pair_a(1, 1, MAG_HI, 21'd100);
    end
    push_a(0, 1, 0, 0);
    pair_a(0, 1, MAG_HI, 21'd100);
    for (int i = 0; i < 20; i++) pair_a(0, 0, '0, '0);

    // Minimal configuration: single-pair lock and end, no hold-off.
    push_b(1, 0, 0, 0);
    pair_b(1, 1, MAG_HI, 21'd100);
    push_b(0, 1, 0, 1);
    pair_b(1, 1, MAG_LO, 21'd100);
    push_b(1, 0, 0, 0);
    pair_b(1, 1, MAG_HI, 21'd100);
    push_b(0, 1, 0, 1);
    pair_b(1, 1, MAG_LO, 21'd100);
    for (int i = 0; i < 6; i++) pair_b(0, 0, '0, '0);

    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
